axis_round_sequencer: RTL and testbench

AXIS_ROUND_SEQUENCER -- requirements
Module: axis_round_sequencer

---
 rtl/axis_round_sequencer_pkg.sv | 36 +++
 rtl/axis_round_sequencer_seq_tick_counter.sv | 36 +++
 rtl/axis_round_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_axis_round_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_round_sequencer_pkg.sv
// Shared definitions for the axis round sequencer: FSM states, axis codes,
// sample width, default timing parameters and a counter-width helper.
package axis_round_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_GAP    = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Axis codes presented on rd_axis; code 3 is never produced
  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  // Width of one axis sample
  localparam int unsigned DATA_W = 12;

  // Default timing parameters
  localparam int unsigned DEF_HOLD_TICKS  = 64;
  localparam int unsigned DEF_GAP_TICKS   = 100;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;

  // Smallest counter width able to represent max_val (never less than 1 bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd2) begin
      return 1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage

// File: rtl/axis_round_sequencer_seq_tick_counter.sv
// Clearable up-counter that advances on an enable and saturates at MAX_VAL,
// so it can never wrap back to zero.
module seq_tick_counter
  import axis_round_sequencer_pkg::*;
#(
  parameter int unsigned MAX_VAL = DEF_GAP_TICKS,
  parameter int unsigned CNT_W   = cnt_width(MAX_VAL)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Count register: clear has priority over enable; holds once MAX_VAL is hit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en && (r_count != MAX_C)) begin
      r_count <= r_count + ONE_C;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/axis_round_sequencer.sv
// Axis round sequencer: after a power-on hold of HOLD_TICKS ticks it enables
// the sensor, then repeatedly waits GAP_TICKS ticks and (while run=1) reads
// X, Y and Z through a shared reader, latching each sample. A read that gets
// no answer within TIMEOUT_CYC cycles is skipped and flagged on sticky err.
//
// rd_start and round_done are registered decodes of the ISSUE and FINISH
// states, so each appears in the cycle after its state; this yields a
// rd_start-to-rd_start spacing of reader response time plus two cycles.
module axis_round_sequencer
  import axis_round_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int unsigned GAP_TICKS   = DEF_GAP_TICKS,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tick,
  input  logic              run,
  output logic              rd_start,
  output logic [1:0]        rd_axis,
  input  logic              rd_done,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] x_reg_temp,
  output logic [DATA_W-1:0] y_reg_temp,
  output logic [DATA_W-1:0] z_reg_temp,
  output logic              sensor_en,
  output logic              round_done,
  output logic              err
);

  localparam int unsigned HOLD_W = cnt_width(HOLD_TICKS);
  localparam int unsigned GAP_W  = cnt_width(GAP_TICKS);
  localparam int unsigned TO_W   = cnt_width(TIMEOUT_CYC);

  // Compare points: the hold expires on the tick that follows HOLD_TICKS-1
  // counted ticks; a read times out in its TIMEOUT_CYC-th cycle of WAIT.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 32'd1);
  localparam logic [GAP_W-1:0]  GAP_FULL  = GAP_W'(GAP_TICKS);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 32'd1);

  state_t r_state;
  state_t w_next_state;

  logic [1:0]        r_axis;
  logic              r_rd_start;
  logic              r_round_done;
  logic              r_sensor_en;
  logic              r_err;
  logic [DATA_W-1:0] r_x_temp;
  logic [DATA_W-1:0] r_y_temp;
  logic [DATA_W-1:0] r_z_temp;

  logic              w_hold_expire;
  logic              w_round_start;
  logic              w_capture;
  logic              w_timeout;
  logic              w_axis_inc;

  logic              w_hold_en;
  logic              w_gap_en;
  logic              w_gap_clr;
  logic              w_to_en;
  logic              w_to_clr;
  logic [HOLD_W-1:0] w_hold_cnt;
  logic [GAP_W-1:0]  w_gap_cnt;
  logic [TO_W-1:0]   w_to_cnt;

  // Ticks only count in HOLD and GAP; the timeout only runs while waiting
  // without an answer, so rd_done and tick have no effect elsewhere.
  assign w_hold_en = (r_state == ST_HOLD) && tick;
  assign w_gap_en  = (r_state == ST_GAP) && tick;
  assign w_gap_clr = w_hold_expire || (r_state == ST_FINISH);
  assign w_to_en   = (r_state == ST_WAIT) && !rd_done;
  assign w_to_clr  = (r_state == ST_ISSUE);

  seq_tick_counter #(
    .MAX_VAL (HOLD_TICKS),
    .CNT_W   (HOLD_W)
  ) u_hold_cnt (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (1'b0),
    .i_en    (w_hold_en),
    .o_count (w_hold_cnt)
  );

  seq_tick_counter #(
    .MAX_VAL (GAP_TICKS),
    .CNT_W   (GAP_W)
  ) u_gap_cnt (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_gap_clr),
    .i_en    (w_gap_en),
    .o_count (w_gap_cnt)
  );

  seq_tick_counter #(
    .MAX_VAL (TIMEOUT_CYC),
    .CNT_W   (TO_W)
  ) u_to_cnt (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_clr   (w_to_clr),
    .i_en    (w_to_en),
    .o_count (w_to_cnt)
  );

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_HOLD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus one-cycle control strobes for the datapath
  always_comb begin
    w_next_state  = r_state;
    w_hold_expire = 1'b0;
    w_round_start = 1'b0;
    w_capture     = 1'b0;
    w_timeout     = 1'b0;
    w_axis_inc    = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (tick && (w_hold_cnt == HOLD_LAST)) begin
          w_hold_expire = 1'b1;
          w_next_state  = ST_GAP;
        end else begin
          w_next_state  = ST_HOLD;
        end
      end
      ST_GAP: begin
        if ((w_gap_cnt == GAP_FULL) && run) begin
          w_round_start = 1'b1;
          w_next_state  = ST_ISSUE;
        end else begin
          w_next_state  = ST_GAP;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // An answer in the timeout cycle still counts as an answer
        if (rd_done) begin
          w_capture = 1'b1;
        end else if (w_to_cnt == TO_LAST) begin
          w_timeout = 1'b1;
        end else begin
          w_capture = 1'b0;
        end
        if (w_capture || w_timeout) begin
          if (r_axis == AXIS_Z) begin
            w_next_state = ST_FINISH;
          end else begin
            w_axis_inc   = 1'b1;
            w_next_state = ST_ISSUE;
          end
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_FINISH: begin
        w_next_state = ST_GAP;
      end
      default: begin
        w_next_state = ST_HOLD;
      end
    endcase
  end

  // Axis selector: restarts at X for each round, steps after each read
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_axis <= AXIS_X;
    end else if (w_round_start) begin
      r_axis <= AXIS_X;
    end else if (w_axis_inc) begin
      r_axis <= r_axis + 2'd1;
    end else begin
      r_axis <= r_axis;
    end
  end

  // Registered one-cycle strobes decoded from the ISSUE and FINISH states
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_start   <= 1'b0;
      r_round_done <= 1'b0;
    end else begin
      r_rd_start   <= (r_state == ST_ISSUE);
      r_round_done <= (r_state == ST_FINISH);
    end
  end

  // Sticky status: sensor enable after hold, error after any timeout
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sensor_en <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sensor_en <= r_sensor_en | w_hold_expire;
      r_err       <= r_err | w_timeout;
    end
  end

  // Sample capture into the register of the axis being read
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_x_temp <= {DATA_W{1'b0}};
      r_y_temp <= {DATA_W{1'b0}};
      r_z_temp <= {DATA_W{1'b0}};
    end else if (w_capture) begin
      case (r_axis)
        AXIS_X:  r_x_temp <= rd_data;
        AXIS_Y:  r_y_temp <= rd_data;
        AXIS_Z:  r_z_temp <= rd_data;
        default: r_x_temp <= r_x_temp;
      endcase
    end else begin
      r_x_temp <= r_x_temp;
    end
  end

  assign rd_start   = r_rd_start;
  assign rd_axis    = r_axis;
  assign round_done = r_round_done;
  assign sensor_en  = r_sensor_en;
  assign err        = r_err;
  assign x_reg_temp = r_x_temp;
  assign y_reg_temp = r_y_temp;
  assign z_reg_temp = r_z_temp;

endmodule

// File: tb/tb_axis_round_sequencer.sv
// Self-checking bench for axis_round_sequencer. The bench plays the tick
// source and the shared axis reader; a small model (expected sample per axis,
// expected sticky error, accept-if-answered-before-timeout rule) predicts the
// outputs after every read.
module tb_axis_round_sequencer;
  import axis_round_sequencer_pkg::*;

  localparam int unsigned P_HOLD = 64;
  localparam int unsigned P_GAP  = 2;
  localparam int unsigned P_TO   = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        tick;
  logic        run;
  logic        rd_start;
  logic [1:0]  rd_axis;
  logic        rd_done;
  logic [11:0] rd_data;
  logic [11:0] x_reg_temp;
  logic [11:0] y_reg_temp;
  logic [11:0] z_reg_temp;
  logic        sensor_en;
  logic        round_done;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_temp [3];
  logic        exp_err;

  always #5 CLK = ~CLK;

  axis_round_sequencer #(
    .HOLD_TICKS  (P_HOLD),
    .GAP_TICKS   (P_GAP),
    .TIMEOUT_CYC (P_TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tick       (tick),
    .run        (run),
    .rd_start   (rd_start),
    .rd_axis    (rd_axis),
    .rd_done    (rd_done),
    .rd_data    (rd_data),
    .x_reg_temp (x_reg_temp),
    .y_reg_temp (y_reg_temp),
    .z_reg_temp (z_reg_temp),
    .sensor_en  (sensor_en),
    .round_done (round_done),
    .err        (err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_x"}, x_reg_temp, exp_temp[0]);
    check({tag, "_y"}, y_reg_temp, exp_temp[1]);
    check({tag, "_z"}, z_reg_temp, exp_temp[2]);
    check({tag, "_err"}, err, exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_start"}, rd_start, 0);
    check({tag, "_rd_axis"}, rd_axis, 0);
    check({tag, "_sensor_en"}, sensor_en, 0);
    check({tag, "_round_done"}, round_done, 0);
    check_model(tag);
  endtask

  task automatic model_reset();
    exp_temp[0] = 12'h000;
    exp_temp[1] = 12'h000;
    exp_temp[2] = 12'h000;
    exp_err     = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic idle(input int n, output int starts, output int dones);
    starts = 0;
    dones  = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (rd_start === 1'b1) starts++;
      if (round_done === 1'b1) dones++;
    end
  endtask

  task automatic wait_rd_start(input string tag, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      if (rd_start === 1'b1) got = 1'b1;
      else step();
    end
    if (rd_start === 1'b1) got = 1'b1;
    check({tag, "_rd_start_arrives"}, {31'd0, got}, 1);
  endtask

  // Serve one read, starting in the cycle where rd_start is high. The answer
  // is accepted when it lands at latency 1..P_TO-1 from rd_start; otherwise
  // the read times out and, with lat==P_TO, a late pulse is sent anyway.
  task automatic serve(input logic [1:0] ax, input int lat, input bit answer,
                       input logic [11:0] data);
    bit acc;
    int fin;
    acc = answer && (lat >= 1) && (lat <= int'(P_TO) - 1);
    fin = acc ? lat : int'(P_TO) - 1;
    check("rd_start_issued", rd_start, 1);
    check("rd_axis", rd_axis, ax);
    step();
    check("rd_start_one_cycle", rd_start, 0);
    check("rd_axis_hold", rd_axis, ax);
    for (int i = 1; i < fin; i++) step();
    check("err_before_end", err, exp_err);
    check("rd_axis_end", rd_axis, ax);
    if (acc) begin
      rd_done = 1'b1;
      rd_data = data;
    end
    step();
    rd_done = 1'b0;
    if (acc) exp_temp[ax] = data;
    else exp_err = 1'b1;
    if (answer && !acc && lat == int'(P_TO)) begin
      rd_done = 1'b1;
      rd_data = data;
    end
    check_model("after_read");
    check("round_done_early", round_done, 0);
    step();
    rd_done = 1'b0;
    rd_data = 12'($urandom);
    check_model("late_pulse");
    if (ax != AXIS_Z) begin
      check("next_rd_start", rd_start, 1);
      check("next_rd_axis", rd_axis, ax + 2'd1);
    end else begin
      check("round_done_pulse", round_done, 1);
      step();
      check("round_done_width", round_done, 0);
    end
  endtask

  initial begin
    int          starts;
    int          dones;
    int          lat;
    bit          ans;
    logic [11:0] d;

    RST     = 1'b1;
    tick    = 1'b0;
    run     = 1'b1;
    rd_done = 1'b0;
    rd_data = 12'h000;
    model_reset();
    step();
    step();
    check_all_zero("reset");
    RST = 1'b0;

    // Stray answer during HOLD
    rd_done = 1'b1;
    rd_data = 12'hABC;
    step();
    rd_done = 1'b0;
    check_model("stray_hold");

    // Hold period: 63 ticks keep sensor_en low, the 64th raises it
    for (int i = 0; i < int'(P_HOLD) - 1; i++) tick_pulse();
    check("sensor_en_before_hold", sensor_en, 0);
    tick = 1'b1;
    step();
    check("sensor_en_at_hold", sensor_en, 1);
    tick = 1'b0;
    step();

    // One gap tick is not enough; the second starts the round
    tick_pulse();
    idle(6, starts, dones);
    check("no_start_one_gap_tick", starts, 0);
    tick_pulse();
    wait_rd_start("first", 8);

    // Directed round with 5-cycle reader latency
    serve(AXIS_X, 5, 1'b1, 12'h123);
    serve(AXIS_Y, 5, 1'b1, 12'h456);
    serve(AXIS_Z, 5, 1'b1, 12'h789);

    // Round 2: answer on the timeout cycle wins; ticks during reads ignored
    tick_pulse();
    idle(6, starts, dones);
    check("no_start_after_clear", starts, 0);
    tick_pulse();
    wait_rd_start("coincide", 8);
    tick = 1'b1;
    serve(AXIS_X, int'(P_TO) - 1, 1'b1, 12'($urandom));
    serve(AXIS_Y, int'($urandom_range(1, 14)), 1'b1, 12'($urandom));
    tick = 1'b0;
    serve(AXIS_Z, int'(P_TO) - 1, 1'b1, 12'($urandom));

    // Round 3: Y never answers in time (late pulse ignored), Z still read
    tick_pulse();
    tick_pulse();
    wait_rd_start("timeout", 8);
    serve(AXIS_X, int'($urandom_range(1, 14)), 1'b1, 12'($urandom));
    serve(AXIS_Y, int'(P_TO), 1'b1, 12'($urandom));
    serve(AXIS_Z, int'($urandom_range(1, 14)), 1'b1, 12'($urandom));

    // Random rounds; run drops during the last one
    for (int r = 0; r < 4; r++) begin
      tick_pulse();
      tick_pulse();
      wait_rd_start("random", 8);
      for (int a = 0; a < 3; a++) begin
        lat = int'($urandom_range(1, 16));
        ans = ($urandom_range(0, 4) != 0);
        d   = 12'($urandom);
        if (r == 3 && a == 1) run = 1'b0;
        serve(2'(a), lat, ans, d);
      end
    end

    // Parked in GAP: stray answer and extra ticks change nothing
    rd_done = 1'b1;
    rd_data = ~x_reg_temp;
    step();
    rd_done = 1'b0;
    check_model("stray_gap");
    for (int i = 0; i < 4; i++) tick_pulse();
    idle(20, starts, dones);
    check("parked_no_start", starts, 0);
    check("parked_no_round_done", dones, 0);
    check_model("parked");
    run = 1'b1;
    wait_rd_start("resume", 5);

    // Reset while waiting for Y
    serve(AXIS_X, int'($urandom_range(1, 14)), 1'b1, 12'($urandom));
    step();
    step();
    step();
    RST = 1'b1;
    #1;
    model_reset();
    check_all_zero("mid_round_reset");
    step();
    RST = 1'b0;
    idle(30, starts, dones);
    check("after_reset_no_start", starts, 0);
    check("after_reset_no_round_done", dones, 0);
    check("after_reset_sensor_en", sensor_en, 0);

    // Sequence restarts from HOLD
    for (int i = 0; i < int'(P_HOLD); i++) tick_pulse();
    check("sensor_en_rehold", sensor_en, 1);
    tick_pulse();
    tick_pulse();
    wait_rd_start("restart", 8);
    serve(AXIS_X, int'($urandom_range(1, 14)), 1'b1, 12'($urandom));
    serve(AXIS_Y, int'($urandom_range(1, 14)), 1'b1, 12'($urandom));
    serve(AXIS_Z, int'($urandom_range(1, 14)), 1'b1, 12'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
